// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX -> EX -> EX/MEM signal bundle for the MIPS execute stage.
//   master modport : pipeline side (drives the *_in fields and the stall/flush
//                    controls, observes the *_out fields)
//   slave  modport : ex_stage (observes *_in, drives *_out)
interface ex_stage_if;
  logic        stall_current_stage;
  logic        flush;
  logic [5:0]  funct_in;
  logic [4:0]  shamt_in;
  logic [31:0] operand_1_in;
  logic [31:0] operand_2_in;
  logic        mem_read_flag_in;
  logic        mem_write_flag_in;
  logic        mem_sign_ext_flag_in;
  logic [3:0]  mem_sel_in;
  logic [31:0] mem_write_data_in;
  logic        reg_write_en_in;
  logic [4:0]  reg_write_addr_in;
  logic [31:0] current_pc_addr_in;
  logic        cp0_write_en_in;
  logic        cp0_read_en_in;
  logic [7:0]  cp0_addr_in;
  logic [31:0] cp0_write_data_in;
  logic [31:0] cp0_read_data_in;

  logic [31:0] result_out;
  logic        reg_write_en_out;
  logic        overflow_out;
  logic        stall_request_out;
  logic        mem_read_flag_out;
  logic        mem_write_flag_out;
  logic        mem_sign_ext_flag_out;
  logic [3:0]  mem_sel_out;
  logic [31:0] mem_write_data_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] current_pc_addr_out;
  logic        cp0_write_en_out;
  logic        cp0_read_en_out;
  logic [7:0]  cp0_addr_out;
  logic [31:0] cp0_write_data_out;
  logic [31:0] cp0_read_data_out;

  modport slave (
    input  stall_current_stage, flush, funct_in, shamt_in, operand_1_in, operand_2_in,
           mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in, mem_sel_in,
           mem_write_data_in, reg_write_en_in, reg_write_addr_in, current_pc_addr_in,
           cp0_write_en_in, cp0_read_en_in, cp0_addr_in, cp0_write_data_in, cp0_read_data_in,
    output result_out, reg_write_en_out, overflow_out, stall_request_out,
           mem_read_flag_out, mem_write_flag_out, mem_sign_ext_flag_out, mem_sel_out,
           mem_write_data_out, reg_write_addr_out, current_pc_addr_out,
           cp0_write_en_out, cp0_read_en_out, cp0_addr_out, cp0_write_data_out, cp0_read_data_out
  );

  modport master (
    output stall_current_stage, flush, funct_in, shamt_in, operand_1_in, operand_2_in,
           mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in, mem_sel_in,
           mem_write_data_in, reg_write_en_in, reg_write_addr_in, current_pc_addr_in,
           cp0_write_en_in, cp0_read_en_in, cp0_addr_in, cp0_write_data_in, cp0_read_data_in,
    input  result_out, reg_write_en_out, overflow_out, stall_request_out,
           mem_read_flag_out, mem_write_flag_out, mem_sign_ext_flag_out, mem_sel_out,
           mem_write_data_out, reg_write_addr_out, current_pc_addr_out,
           cp0_write_en_out, cp0_read_en_out, cp0_addr_out, cp0_write_data_out, cp0_read_data_out
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage. Combinational ALU/shifter, single-cycle
// MULT/MULTU, HI/LO register pair and (optionally) an iterative radix-2
// restoring divider that stalls the pipeline while busy.
// Ports:
//   clk  - pipeline clock
//   rst  - asynchronous active-low reset
//   bus  - ex_stage_if.slave: operation inputs, pass-through fields, results
// Build option: define EX_DIV_EN to build the divider; without it DIV/DIVU
// are single-cycle no-ops (HI/LO unchanged, result 0, never stall).
//
// Divider FSM:
//   state  | meaning
//   S_IDLE | waiting; a DIV/DIVU on the inputs latches operands
//   S_BUSY | one shift-subtract step per cycle, stall requested
//   S_DONE | HI/LO written on entry; held while the stage is stalled
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input logic      clk,
  input logic      rst,
  ex_stage_if.slave bus
);
  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  logic [31:0] op_a, op_b;
  logic [5:0]  funct;
  logic        stall, flush;
  logic [31:0] hi_q, lo_q, hi_d, lo_d;
  logic [31:0] alu_res, sum, dif;
  logic        alu_ovf;
  logic [63:0] prod_s, prod_u;
  logic        div_wr;
  logic [31:0] div_quo, div_rem;

  assign op_a  = bus.operand_1_in;
  assign op_b  = bus.operand_2_in;
  assign funct = bus.funct_in;
  assign stall = bus.stall_current_stage;
  assign flush = bus.flush;

  // Sign-extend before multiplying so the low 64 bits are the signed product.
  assign prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
  assign prod_u = {32'b0, op_a} * {32'b0, op_b};

  always_comb begin
    sum     = op_a + op_b;
    dif     = op_a - op_b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (funct)
      F_SLL:  alu_res = op_b << bus.shamt_in;
      F_SRL:  alu_res = op_b >> bus.shamt_in;
      F_SRA:  alu_res = $signed(op_b) >>> bus.shamt_in;
      F_SLLV: alu_res = op_b << op_a[4:0];
      F_SRLV: alu_res = op_b >> op_a[4:0];
      F_SRAV: alu_res = $signed(op_b) >>> op_a[4:0];
      F_ADD: begin
        alu_res = sum;
        alu_ovf = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
      end
      F_ADDU: alu_res = sum;
      F_SUB: begin
        alu_res = dif;
        alu_ovf = (op_a[31] != op_b[31]) && (dif[31] != op_a[31]);
      end
      F_SUBU: alu_res = dif;
      F_AND:  alu_res = op_a & op_b;
      F_OR:   alu_res = op_a | op_b;
      F_XOR:  alu_res = op_a ^ op_b;
      F_NOR:  alu_res = ~(op_a | op_b);
      F_SLT:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      F_SLTU: alu_res = {31'b0, op_a < op_b};
      F_MFHI: alu_res = hi_q;
      F_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (!stall && !flush) begin
      case (funct)
        F_MTHI:  hi_d = op_a;
        F_MTLO:  lo_d = op_a;
        F_MULT:  {hi_d, lo_d} = prod_s;
        F_MULTU: {hi_d, lo_d} = prod_u;
        default: ;
      endcase
    end
    if (div_wr) begin
      hi_d = div_rem;
      lo_d = div_quo;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;
  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  div_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]    quo_q, rem_q, dsr_q;
  logic           neg_quo_q, neg_rem_q;
  logic           is_div, div_signed;
  logic [31:0]    a_mag, b_mag;
  logic [32:0]    rem_shift, rem_sub;
  logic           take;
  logic [31:0]    quo_next, rem_next;

  assign is_div     = (funct == F_DIV) || (funct == F_DIVU);
  assign div_signed = (funct == F_DIV);
  assign a_mag      = (div_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign b_mag      = (div_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;

  // Remainder stays below the divisor, so bit 32 of the difference is a
  // clean borrow flag.
  always_comb begin
    rem_shift = {rem_q, quo_q[31]};
    rem_sub   = rem_shift - {1'b0, dsr_q};
    take      = !rem_sub[32];
    rem_next  = take ? rem_sub[31:0] : rem_shift[31:0];
    quo_next  = {quo_q[30:0], take};
  end

  // Final step result is written with sign correction on the DONE entry edge.
  assign div_wr  = (state_q == S_BUSY) && (cnt_q == CNT_W'(1)) && !flush;
  assign div_quo = neg_quo_q ? (~quo_next + 32'd1) : quo_next;
  assign div_rem = neg_rem_q ? (~rem_next + 32'd1) : rem_next;

  assign bus.stall_request_out = !flush &&
      (((state_q == S_IDLE) && is_div) || (state_q == S_BUSY));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_div) begin
            quo_q     <= a_mag;
            rem_q     <= '0;
            dsr_q     <= b_mag;
            neg_quo_q <= div_signed && (op_a[31] ^ op_b[31]);
            neg_rem_q <= div_signed && op_a[31];
            if (op_b == 32'd0) begin
              state_q <= S_DONE;
            end else begin
              cnt_q   <= CNT_W'(DIV_CYCLES);
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          quo_q <= quo_next;
          rem_q <= rem_next;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_DONE;
        end
        S_DONE: begin
          if (!stall) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
`else
  assign div_wr  = 1'b0;
  assign div_quo = '0;
  assign div_rem = '0;
  assign bus.stall_request_out = 1'b0;
`endif

  assign bus.result_out            = alu_res;
  assign bus.overflow_out          = alu_ovf;
  assign bus.reg_write_en_out      = bus.reg_write_en_in & ~alu_ovf;
  assign bus.mem_read_flag_out     = bus.mem_read_flag_in;
  assign bus.mem_write_flag_out    = bus.mem_write_flag_in;
  assign bus.mem_sign_ext_flag_out = bus.mem_sign_ext_flag_in;
  assign bus.mem_sel_out           = bus.mem_sel_in;
  assign bus.mem_write_data_out    = bus.mem_write_data_in;
  assign bus.reg_write_addr_out    = bus.reg_write_addr_in;
  assign bus.current_pc_addr_out   = bus.current_pc_addr_in;
  assign bus.cp0_write_en_out      = bus.cp0_write_en_in;
  assign bus.cp0_read_en_out       = bus.cp0_read_en_in;
  assign bus.cp0_addr_out          = bus.cp0_addr_in;
  assign bus.cp0_write_data_out    = bus.cp0_write_data_in;
  assign bus.cp0_read_data_out     = bus.cp0_read_data_in;
endmodule
